apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
// - APB4 requester: converts a valid/ready command channel into single APB transfers.
// - Returns a buffered response (rdata, error, timeout) on a valid/ready response channel.
// - Initiator end of the bus; drives our APB slave peripherals (LED/RGB/scratch/mem space).
// - Sits between the soft-CPU/UART-debug command source and the APB fabric.
// PARAMETERS
// - AW       32  address width
// - DW       32  data width; multiple of 8
// - SW       4   strobe width; must equal DW/8
// - TIMEOUT  16  max ACCESS cycles waiting for PREADY before abort; 0 = never abort
// PORTS
// - PCLK         in   1      clock; all logic on rising edge
// - PRESETn      in   1      asynchronous, active-low reset
// - cmd_valid    in   1      command present
// - cmd_ready    out  1      command accepted when cmd_valid && cmd_ready at a PCLK edge
// - cmd_write    in   1      1 = write, 0 = read
// - cmd_addr     in   AW     byte address, passed to PADDR unmodified
// - cmd_wdata    in   DW     write data
// - cmd_strb     in   SW     write byte strobes
// - cmd_prot     in   3      PPROT value
// - cmd_nse      in   1      PNSE value
// - rsp_valid    out  1      response present
// - rsp_ready    in   1      response consumed when rsp_valid && rsp_ready at a PCLK edge
// - rsp_rdata    out  DW     read data; 0 for writes and timeouts
// - rsp_err      out  1      PSLVERR captured, or timeout
// - rsp_timeout  out  1      transfer aborted by the timeout
// - PADDR PPROT PNSE PSEL PENABLE PWRITE PWDATA PSTRB  out  APB requester signals
// - PREADY PRDATA PSLVERR                              in   APB completer signals
// BEHAVIOUR
// - Reset:
//   - State IDLE; every registered output is 0, including PSEL, PENABLE, rsp_valid and all APB buses.
//   - cmd_ready = (state==IDLE) && PRESETn, so it reads 0 while reset is asserted.
//   - Reset mid-transfer drops PSEL/PENABLE immediately (async), discards the command and emits no response.
// - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; all APB outputs are registered.
// - IDLE:
//   - On accept, latch cmd_* into the APB output registers and go to SETUP.
// - SETUP (exactly 1 cycle):
//   - PSEL=1, PENABLE=0; PADDR, PWRITE, PPROT, PNSE, PWDATA and PSTRB valid.
//   - Next state is ACCESS.
// - ACCESS:
//   - PSEL=1, PENABLE=1; all APB outputs held stable from SETUP.
//   - PREADY=1 sampled: capture PSLVERR into rsp_err; capture PRDATA into rsp_rdata on reads (0 on writes); go to RESP.
//   - Wait counter clears on entry and increments on each ACCESS cycle with PREADY=0.
//   - TIMEOUT!=0 and PREADY=0 with counter==TIMEOUT-1: go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//     - So ACCESS lasts at most TIMEOUT cycles.
// - RESP:
//   - PSEL=0, PENABLE=0; rsp_valid=1; rsp_* held stable until rsp_ready.
//   - Then IDLE, with rsp_valid=0 the next cycle.
// - Reads drive PSTRB=0 and PWDATA=0.
// - PSEL returns to 0 after every transfer; there is no back-to-back SETUP.
// - Minimum transfer is 4 cycles from accept to IDLE, with PREADY=1 and rsp_ready=1.
// - One outstanding transfer only; cmd_ready=0 outside IDLE.
// - PREADY and PSLVERR are ignored outside ACCESS.
// - PSLVERR on a read still returns the captured PRDATA.
// TESTING
// - Write 0x4000_1004 / 0x0000_002A / strb 0xF, PREADY=1 in first ACCESS
//   -> PSEL high 2 cycles, PENABLE 1 cycle; rsp_valid one cycle after ACCESS, rsp_err=0.
// - Read 0x4000_100C, 3 PREADY=0 wait states, then PRDATA=0xA735_0001
//   -> ACCESS lasts 4 cycles, PADDR stable throughout, PSTRB=0; rsp_rdata=0xA735_0001.
// - Write with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
// - PREADY held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, PSEL=0.
// - rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0; a new cmd_valid is not accepted until after the handshake.
// - PRESETn pulsed low in ACCESS -> PSEL=PENABLE=rsp_valid=0 at once; a fresh read after release completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB4 requester: turns one valid/ready command into one APB transfer and
// returns a buffered response (rdata, error, timeout) on a valid/ready channel.
module apb_master_bridge #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned SW      = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    // Both channels: a beat transfers on a PCLK rising edge where valid && ready;
    // the sender holds its payload stable while valid is high and ready is low.
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [SW-1:0] cmd_strb,
    input  logic [2:0]    cmd_prot,
    input  logic          cmd_nse,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_timeout,
    output logic [AW-1:0] PADDR,
    output logic [2:0]    PPROT,
    output logic          PNSE,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [DW-1:0] PWDATA,
    output logic [SW-1:0] PSTRB,
    input  logic          PREADY,
    input  logic [DW-1:0] PRDATA,
    input  logic          PSLVERR,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [2:0]    pprot_q, pprot_d;
    logic          pnse_q, pnse_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0] pstrb_q, pstrb_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          timeout_hit;

    // The last permitted wait cycle is the one where the counter reads TIMEOUT-1.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && !PREADY && (wait_cnt_q == CW'(TIMEOUT - 1));
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        pnse_d        = pnse_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pprot_d  = cmd_prot;
                    pnse_d   = cmd_nse;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            paddr_q       <= '0;
            pprot_q       <= '0;
            pnse_q        <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            pnse_q        <= pnse_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Gated with PRESETn so no command can be offered while reset is held.
    assign cmd_ready   = (state_q == IDLE) && PRESETn;
    assign PADDR       = paddr_q;
    assign PPROT       = pprot_q;
    assign PNSE        = pnse_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: table of directed transfers with a reactive APB
// completer, plus hand-written sequences for response backpressure and mid-transfer reset.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic [2:0]    cmd_prot;
    logic          cmd_nse;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic [2:0]    PPROT;
    logic          PNSE;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;
    logic [1:0]    dbg_state;

    apb_master_bridge #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .cmd_nse(cmd_nse),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PPROT(PPROT), .PNSE(PNSE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        logic [2:0]    prot;
        logic          nse;
        int            waits;      // PREADY=0 cycles before completion; 255 = never ready
        logic          slverr;
        logic [31:0]   prdata;
        int            hold;       // cycles rsp_ready stays 0 after rsp_valid
        int            exp_acc;    // expected ACCESS cycles
        logic [31:0]   exp_pwdata;
        logic [3:0]    exp_pstrb;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        logic          exp_to;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic completer_idle();
        // Driven outside ACCESS; the bridge must ignore these.
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'hDEAD_BEEF;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // driver + completer model for one table transfer
    task automatic do_xfer(input vec_t v, input string tag);
        int          acc;
        int          sel;
        bit          seen;
        bit          stable_ok;
        bit          setup_seen;
        bit          hold_ok;
        logic [72:0] snap;
        acc = 0; sel = 0; seen = 1'b0; stable_ok = 1'b1; setup_seen = 1'b0; hold_ok = 1'b1;
        snap = '0;
        @(negedge PCLK);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cmd_strb = v.strb; cmd_prot = v.prot; cmd_nse = v.nse;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0BAD_0BAD;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (PSEL) sel++;
            if (PSEL && !PENABLE) begin
                chk({tag, "_setup_addr"}, PADDR, v.addr);
                chk({tag, "_setup_ctl"}, {PWRITE, PPROT, PNSE, PSTRB}, {v.wr, v.prot, v.nse, v.exp_pstrb});
                chk({tag, "_setup_wdata"}, PWDATA, v.exp_pwdata);
                snap = {PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE};
                setup_seen = 1'b1;
                completer_idle();
            end else if (PSEL && PENABLE) begin
                if (!setup_seen || {PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE} != snap) stable_ok = 1'b0;
                if (acc >= v.waits) begin
                    PREADY = 1'b1; PSLVERR = v.slverr; PRDATA = v.prdata;
                end else begin
                    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h1111_1111;
                end
                acc++;
            end else begin
                completer_idle();
            end
            @(negedge PCLK);
        end
        completer_idle();
        chk({tag, "_rsp_seen"}, seen, 1);
        chk({tag, "_psel_cycles"}, sel, v.exp_acc + 1);
        chk({tag, "_access_cycles"}, acc, v.exp_acc);
        chk({tag, "_apb_stable"}, stable_ok, 1);
        chk({tag, "_bus_released"}, {PSEL, PENABLE}, 2'b00);
        chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_rsp_err_to"}, {rsp_err, rsp_timeout}, {v.exp_err, v.exp_to});
        rsp_ready = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge PCLK);
            if (!rsp_valid || cmd_ready || PSEL || rsp_rdata != v.exp_rdata ||
                {rsp_err, rsp_timeout} != {v.exp_err, v.exp_to}) hold_ok = 1'b0;
        end
        if (v.hold > 0) chk({tag, "_rsp_hold"}, hold_ok, 1);
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    vec_t vecs[7];
    vec_t rst_vec;

    initial begin
        bit ok;
        bit hold_ok;

        vecs[0] = '{1'b1, 32'h4000_1004, 32'h0000_002A, 4'hF, 3'd0, 1'b0, 0, 1'b0, 32'h0000_0000, 0, 1,
                    32'h0000_002A, 4'hF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h4000_100C, 32'hFFFF_FFFF, 4'hF, 3'd2, 1'b0, 3, 1'b0, 32'hA735_0001, 0, 4,
                    32'h0000_0000, 4'h0, 32'hA735_0001, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h4000_2008, 32'hCAFE_0123, 4'h3, 3'd5, 1'b1, 1, 1'b1, 32'h5555_5555, 0, 2,
                    32'hCAFE_0123, 4'h3, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h4000_3000, 32'h0000_0000, 4'h0, 3'd1, 1'b0, 0, 1'b1, 32'h1234_5678, 1, 1,
                    32'h0000_0000, 4'h0, 32'h1234_5678, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'h4000_0FF0, 32'h0000_0000, 4'h0, 3'd0, 1'b0, 255, 1'b0, 32'h7777_7777, 0, 16,
                    32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h4000_1000, 32'h0000_00FF, 4'h1, 3'd0, 1'b1, 2, 1'b0, 32'h0000_0000, 5, 3,
                    32'h0000_00FF, 4'h1, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h4000_4000, 32'h8000_0001, 4'hC, 3'd7, 1'b0, 255, 1'b0, 32'h9999_9999, 2, 16,
                    32'h8000_0001, 4'hC, 32'h0000_0000, 1'b1, 1'b1};
        rst_vec = '{1'b0, 32'h4000_0010, 32'h0000_0000, 4'h0, 3'd0, 1'b0, 1, 1'b0, 32'h0F0F_F0F0, 0, 2,
                    32'h0000_0000, 4'h0, 32'h0F0F_F0F0, 1'b0, 1'b0};

        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; cmd_nse = 1'b0; rsp_ready = 1'b0;
        completer_idle();
        repeat (3) @(negedge PCLK);
        chk("rst_ctl", {PSEL, PENABLE, rsp_valid, cmd_ready, rsp_err, rsp_timeout}, 6'b0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_data", {PWDATA, rsp_rdata}, 0);
        chk("rst_apb_misc", {PSTRB, PPROT, PNSE, PWRITE}, 0);
        chk("rst_state", dbg_state, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_rst_ready", cmd_ready, 1);

        for (int i = 0; i < 7; i++) do_xfer(vecs[i], $sformatf("vec%0d", i));

        // A command offered while the response is held must wait for the handshake.
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0BAD_F00D;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_2000;
        cmd_wdata = 32'h0000_0055; cmd_strb = 4'hF; cmd_prot = 3'd0; cmd_nse = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        wait_rsp(ok);
        chk("bp_rsp_seen", ok, 1);
        chk("bp_wr_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 34'h0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_3000;
        hold_ok = 1'b1;
        for (int h = 0; h < 5; h++) begin
            @(negedge PCLK);
            if (!rsp_valid || cmd_ready || PSEL) hold_ok = 1'b0;
        end
        chk("bp_no_accept", hold_ok, 1);
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk("bp_after_hs", {rsp_valid, cmd_ready, PSEL}, 3'b010);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("bp_new_setup", {PSEL, PENABLE, PWRITE}, 3'b100);
        chk("bp_new_addr", PADDR, 32'h4000_3000);
        wait_rsp(ok);
        chk("bp_rd_seen", ok, 1);
        chk("bp_rd_rdata", rsp_rdata, 32'h0BAD_F00D);
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;

        // Reset asserted in the middle of ACCESS.
        PREADY = 1'b0; PSLVERR = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0020;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_mid_in_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_mid_ctl", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0);
        chk("rst_mid_state", dbg_state, 0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        completer_idle();
        do_xfer(rst_vec, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
